// File: rtl/ec_pkg.sv
// Shared elliptic-curve definitions: FSM states, curve and identity constants,
// modular helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Curve: y^2 = x^3 + CURVE_A*x + CURVE_B over GF(DEF_MOD). With a=1, b=6 and
// a field modulus of 7 the group has 11 points (prime order), so there is no
// point of order two and the projective addition formula in pointAddition is
// complete.
package ec_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DBL  = 3'd1,
    ADD  = 3'd2,
    NEG  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int unsigned DEF_MOD = 7;
  localparam int unsigned CURVE_A = 1;
  localparam int unsigned CURVE_B = 6;

  // Projective identity (point at infinity).
  localparam int unsigned ID_X = 0;
  localparam int unsigned ID_Y = 1;
  localparam int unsigned ID_Z = 0;

  // (m - y) mod m, with y first reduced so any input value is safe.
  function automatic int unsigned mod_neg(input int unsigned y, input int unsigned m);
    return (m - (y % m)) % m;
  endfunction

endpackage

// File: rtl/pointAddition.sv
// Complete projective point addition on y^2 = x^3 + a*x + b over GF(MOD).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports: (x1,y1,z1) + (x2,y2,z2) -> (x3,y3,z3), all N-bit reduced coordinates.
// The formula is valid for P+Q, P+P and either operand being the identity,
// so one instance can serve doubling, adding and the final addition.
module pointAddition
  import ec_pkg::*;
#(
  parameter int          N   = 3,
  parameter int unsigned MOD = DEF_MOD
) (
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic [N-1:0] z1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] y2,
  input  logic [N-1:0] z2,
  output logic [N-1:0] x3,
  output logic [N-1:0] y3,
  output logic [N-1:0] z3
);

  localparam int unsigned M  = MOD;
  localparam int unsigned AA = CURVE_A % M;
  localparam int unsigned B3 = (3 * CURVE_B) % M;
  localparam int unsigned A2 = (AA * AA) % M;

  int unsigned ux1, uy1, uz1, ux2, uy2, uz2;
  int unsigned t0, t1, t2, t3, t4, t5;
  int unsigned u, s, p, w, v;

  always_comb begin
    ux1 = 32'(x1);
    uy1 = 32'(y1);
    uz1 = 32'(z1);
    ux2 = 32'(x2);
    uy2 = 32'(y2);
    uz2 = 32'(z2);

    t0 = (ux1 * ux2) % M;
    t1 = (uy1 * uy2) % M;
    t2 = (uz1 * uz2) % M;
    t3 = (ux1 * uy2 + ux2 * uy1) % M;
    t4 = (ux1 * uz2 + ux2 * uz1) % M;
    t5 = (uy1 * uz2 + uy2 * uz1) % M;

    // u = a*(X1Z2+X2Z1) + 3b*Z1Z2
    u = (AA * t4 + B3 * t2) % M;
    s = (t1 + M - u) % M;            // Y1Y2 - u
    p = (t1 + u) % M;                // Y1Y2 + u
    w = (3 * t0 + AA * t2) % M;      // 3X1X2 + a*Z1Z2
    // v = 3b*(X1Z2+X2Z1) + a*X1X2 - a^2*Z1Z2
    v = (B3 * t4 + AA * t0 + M - ((A2 * t2) % M)) % M;

    x3 = N'((t3 * s + M - ((t5 * v) % M)) % M);
    y3 = N'((p * s + w * v) % M);
    z3 = N'((t5 * p + t3 * w) % M);
  end

endmodule

// File: rtl/decryption.sv
// EC-ElGamal decryption: P = C2 - d*C1 via MSB-first double-and-add.
// Latency: 2K+2 edges from accept to completion pulse (K+popcount(d)+2 with
//          DECRYPT_SKIP_ZERO_EN). Backpressure: none; start is ignored while busy.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request, sampled only when idle
//   d_key               private scalar, captured at accept
//   x/y/z_C1, x/y/z_C2  ciphertext points (projective), captured at accept
//   x/y/z_P             recovered plaintext point, registered, held until next result
//   busy                high while an operation is in flight
//   Decryption_complete one-cycle pulse when x/y/z_P are updated
// Build option: DECRYPT_SKIP_ZERO_EN skips the ADD cycle for zero key bits
// (data-dependent timing, debug use only).
module decryption
  import ec_pkg::*;
#(
  parameter int          N   = 3,
  parameter int          K   = 4,
  parameter int unsigned MOD = DEF_MOD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] d_key,
  input  logic [N-1:0] x_C1,
  input  logic [N-1:0] y_C1,
  input  logic [N-1:0] z_C1,
  input  logic [N-1:0] x_C2,
  input  logic [N-1:0] y_C2,
  input  logic [N-1:0] z_C2,
  output logic [N-1:0] x_P,
  output logic [N-1:0] y_P,
  output logic [N-1:0] z_P,
  output logic         busy,
  output logic         Decryption_complete
);

  localparam int          IW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(K - 1);
  localparam logic [N-1:0] ID_XN = N'(ID_X);
  localparam logic [N-1:0] ID_YN = N'(ID_Y);
  localparam logic [N-1:0] ID_ZN = N'(ID_Z);

  state_t state, state_nxt;

  logic [IW-1:0] idx;
  logic [K-1:0]  d_r;
  logic [N-1:0]  c1x, c1y, c1z;
  logic [N-1:0]  c2x, c2y, c2z;
  logic [N-1:0]  ax, ay, az;

  logic [N-1:0]  op1x, op1y, op1z;
  logic [N-1:0]  op2x, op2y, op2z;
  logic [N-1:0]  sum_x, sum_y, sum_z;

  logic bit_set;
  logic accept, a_load, a_neg, idx_dec, res_load;

  assign bit_set = d_r[idx];
  assign busy    = (state != IDLE);

  pointAddition #(
    .N  (N),
    .MOD(MOD)
  ) u_padd (
    .x1(op1x),
    .y1(op1y),
    .z1(op1z),
    .x2(op2x),
    .y2(op2y),
    .z2(op2z),
    .x3(sum_x),
    .y3(sum_y),
    .z3(sum_z)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, adder operand muxing and datapath strobes.
  always_comb begin
    state_nxt = state;
    op1x = ax;  op1y = ay;  op1z = az;
    op2x = ax;  op2y = ay;  op2z = az;
    accept   = 1'b0;
    a_load   = 1'b0;
    a_neg    = 1'b0;
    idx_dec  = 1'b0;
    res_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = DBL;
        end
      end
      DBL: begin
        a_load = 1'b1;
`ifdef DECRYPT_SKIP_ZERO_EN
        if (bit_set) begin
          state_nxt = ADD;
        end else if (idx == '0) begin
          state_nxt = NEG;
        end else begin
          idx_dec   = 1'b1;
          state_nxt = DBL;
        end
`else
        state_nxt = ADD;
`endif
      end
      ADD: begin
        op2x = c1x;  op2y = c1y;  op2z = c1z;
        // The add is always performed so timing does not depend on d;
        // only the write-back is conditional.
        a_load = bit_set;
        if (idx == '0) begin
          state_nxt = NEG;
        end else begin
          idx_dec   = 1'b1;
          state_nxt = DBL;
        end
      end
      NEG: begin
        a_neg     = 1'b1;
        state_nxt = FIN;
      end
      FIN: begin
        op1x = c2x;  op1y = c2y;  op1z = c2z;
        res_load  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      d_r <= '0;
      c1x <= '0;  c1y <= '0;  c1z <= '0;
      c2x <= '0;  c2y <= '0;  c2z <= '0;
      ax  <= ID_XN;
      ay  <= ID_YN;
      az  <= ID_ZN;
      x_P <= '0;
      y_P <= '0;
      z_P <= '0;
      Decryption_complete <= 1'b0;
    end else begin
      Decryption_complete <= res_load;
      if (accept) begin
        d_r <= d_key;
        c1x <= x_C1;  c1y <= y_C1;  c1z <= z_C1;
        c2x <= x_C2;  c2y <= y_C2;  c2z <= z_C2;
        ax  <= ID_XN;
        ay  <= ID_YN;
        az  <= ID_ZN;
        idx <= I_TOP;
      end
      if (a_load) begin
        ax <= sum_x;
        ay <= sum_y;
        az <= sum_z;
      end
      if (a_neg) begin
        ay <= N'(mod_neg(32'(ay), MOD));
      end
      if (idx_dec) begin
        idx <= idx - IW'(1);
      end
      if (res_load) begin
        x_P <= sum_x;
        y_P <= sum_y;
        z_P <= sum_z;
      end
    end
  end

endmodule

// File: tb/tb_decryption.sv
// Bench for decryption: affine chord-and-tangent reference model with modular
// inverses, scalar multiply by repeated addition, randomized points and keys.
module tb_decryption;

  localparam int N = 3;
  localparam int K = 4;
  localparam int CA = 1;
  localparam int CB = 6;

  typedef struct packed {
    logic       inf;
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [K-1:0] d_key;
  logic [N-1:0] x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
  logic [N-1:0] x_P, y_P, z_P;
  logic         busy, Decryption_complete;

  int vectors = 0;
  int miscompares = 0;
  pt_t curve_pts[$];
  pt_t G;

  always #5 clk = ~clk;

  decryption #(.N(N), .K(K), .MOD(7)) dut (
    .clk(clk), .reset(reset), .start(start), .d_key(d_key),
    .x_C1(x_C1), .y_C1(y_C1), .z_C1(z_C1),
    .x_C2(x_C2), .y_C2(y_C2), .z_C2(z_C2),
    .x_P(x_P), .y_P(y_P), .z_P(z_P),
    .busy(busy), .Decryption_complete(Decryption_complete)
  );

  // ---------------- reference model ----------------
  function automatic int md(input int v);
    int r;
    r = v % 7;
    if (r < 0) r += 7;
    return r;
  endfunction

  function automatic int inv(input int v);
    for (int k = 1; k < 7; k++) if (md(md(v) * k) == 1) return k;
    return 0;
  endfunction

  function automatic pt_t mk(input int inf, input int x, input int y);
    pt_t r;
    r.inf = (inf != 0);
    r.x = 4'(x);
    r.y = 4'(y);
    return r;
  endfunction

  function automatic pt_t pt_add(input pt_t p, input pt_t q);
    int px, py, qx, qy, lam, rx, ry;
    if (p.inf) return q;
    if (q.inf) return p;
    px = int'(p.x); py = int'(p.y); qx = int'(q.x); qy = int'(q.y);
    if (px == qx && md(py + qy) == 0) return mk(1, 0, 0);
    if (px == qx) lam = md((3 * px * px + CA) * inv(2 * py));
    else          lam = md((qy - py) * inv(qx - px));
    rx = md(lam * lam - px - qx);
    ry = md(lam * (px - rx) - py);
    return mk(0, rx, ry);
  endfunction

  function automatic pt_t pt_mul(input int d, input pt_t p);
    pt_t r;
    r = mk(1, 0, 0);
    for (int k = 0; k < d; k++) r = pt_add(r, p);
    return r;
  endfunction

  function automatic pt_t pt_neg(input pt_t p);
    if (p.inf) return p;
    return mk(0, int'(p.x), md(-int'(p.y)));
  endfunction

  function automatic pt_t expect_dec(input int d, input pt_t c1, input pt_t c2);
    return pt_add(c2, pt_neg(pt_mul(d, c1)));
  endfunction

  // Projective -> affine; a malformed infinity maps to an impossible value.
  function automatic pt_t to_affine(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    int zi;
    if (z == 0) begin
      if (x == 0 && y != 0) return mk(1, 0, 0);
      return mk(0, 15, 15);
    end
    zi = inv(int'(z));
    return mk(0, md(int'(x) * zi), md(int'(y) * zi));
  endfunction

  function automatic int exp_lat(input logic [K-1:0] d);
`ifdef DECRYPT_SKIP_ZERO_EN
    return K + $countones(d) + 2;
`else
    return 2 * K + 2 + 0 * $countones(d);
`endif
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic gen_point(output logic [N-1:0] px, output logic [N-1:0] py,
                           output logic [N-1:0] pz, output pt_t p);
    int k;
    int lam;
    k = int'($urandom_range(0, curve_pts.size()));
    lam = int'($urandom_range(1, 6));
    if (k == curve_pts.size()) begin
      p = mk(1, 0, 0);
      px = '0; py = 3'(lam); pz = '0;
    end else begin
      p = curve_pts[k];
      px = 3'(md(int'(p.x) * lam));
      py = 3'(md(int'(p.y) * lam));
      pz = 3'(lam);
    end
  endtask

  // Starts one operation from a negedge with the DUT idle; returns at the
  // negedge of the completion cycle (lat = -1 on timeout).
  task automatic run_op(input logic [K-1:0] d,
                        input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [N-1:0] e1,
                        input logic [N-1:0] a2, input logic [N-1:0] b2, input logic [N-1:0] e2,
                        output int lat, output bit busy_ok, output pt_t got);
    d_key = d;
    x_C1 = a1; y_C1 = b1; z_C1 = e1;
    x_C2 = a2; y_C2 = b2; z_C2 = e2;
    start = 1'b1;
    busy_ok = 1'b1;
    lat = -1;
    @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (Decryption_complete) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    got = to_affine(x_P, y_P, z_P);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; d_key = '0;
    x_C1 = '0; y_C1 = '0; z_C1 = '0; x_C2 = '0; y_C2 = '0; z_C2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({x_P, y_P, z_P} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %0h expected 0", {x_P, y_P, z_P});
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy);
    end
    vectors++;
    if (Decryption_complete !== 1'b0) begin
      miscompares++; $display("FAIL reset_complete: got %0b expected 0", Decryption_complete);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || Decryption_complete !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset: got busy=%0b done=%0b expected 0 0", busy, Decryption_complete);
    end
  endtask

  task automatic test_latency();
    int lat; bit bok; pt_t got;
    // 11*G is the identity for this curve, so G - 11*G = G.
    run_op(4'b1011, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, lat, bok, got);
    vectors++;
    if (lat != exp_lat(4'b1011)) begin
      miscompares++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat(4'b1011));
    end
    vectors++;
    if (!bok) begin
      miscompares++; $display("FAIL latency_busy_held: got 0 expected 1");
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_at_complete: got %0b expected 0", busy);
    end
    vectors++;
    if (got !== G) begin
      miscompares++; $display("FAIL latency_result: got %0h expected %0h", got, G);
    end
    @(negedge clk);
    vectors++;
    if (Decryption_complete !== 1'b0) begin
      miscompares++; $display("FAIL complete_one_cycle: got %0b expected 0", Decryption_complete);
    end
    vectors++;
    if (to_affine(x_P, y_P, z_P) !== G) begin
      miscompares++; $display("FAIL output_hold: got %0h expected %0h", to_affine(x_P, y_P, z_P), G);
    end
  endtask

  task automatic test_round_trip();
    int lat; bit bok; pt_t got, q, c1, c2;
    q  = pt_mul(4, G);
    c1 = pt_mul(3, G);
    c2 = pt_add(G, pt_mul(3, q));
    run_op(4'd4, 3'(c1.x), 3'(c1.y), 3'd1, 3'(c2.x), 3'(c2.y), 3'd1, lat, bok, got);
    vectors++;
    if (got !== G) begin
      miscompares++; $display("FAIL round_trip: got %0h expected %0h", got, G);
    end
  endtask

  task automatic test_d_zero();
    int lat; bit bok; pt_t got, c1;
    logic [N-1:0] a, b, e;
    gen_point(a, b, e, c1);
    run_op(4'd0, a, b, e, 3'd2, 3'd3, 3'd1, lat, bok, got);
    vectors++;
    if (got !== mk(0, 2, 3)) begin
      miscompares++; $display("FAIL d_zero: got %0h expected %0h", got, mk(0, 2, 3));
    end
    vectors++;
    if (lat != exp_lat(4'd0)) begin
      miscompares++; $display("FAIL d_zero_latency: got %0d expected %0d", lat, exp_lat(4'd0));
    end
  endtask

  task automatic test_c1_identity();
    int lat; bit bok; pt_t got, c2;
    logic [N-1:0] a, b, e;
    gen_point(a, b, e, c2);
    run_op(4'b1111, 3'd0, 3'd1, 3'd0, a, b, e, lat, bok, got);
    vectors++;
    if (got !== c2) begin
      miscompares++; $display("FAIL c1_identity: got %0h expected %0h", got, c2);
    end
  endtask

  task automatic test_random();
    int lat; bit bok; pt_t got, c1, c2, ex;
    logic [N-1:0] a1, b1, e1, a2, b2, e2;
    logic [K-1:0] d;
    for (int t = 0; t < 16; t++) begin
      gen_point(a1, b1, e1, c1);
      gen_point(a2, b2, e2, c2);
      d = K'($urandom);
      ex = expect_dec(int'(d), c1, c2);
      run_op(d, a1, b1, e1, a2, b2, e2, lat, bok, got);
      vectors++;
      if (got !== ex) begin
        miscompares++; $display("FAIL random_result[%0d]: got %0h expected %0h (d=%0h)", t, got, ex, d);
      end
      vectors++;
      if (lat != exp_lat(d) || !bok) begin
        miscompares++; $display("FAIL random_timing[%0d]: got lat=%0d busy_ok=%0b expected lat=%0d busy_ok=1", t, lat, bok, exp_lat(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    pt_t c1, c2, ex;
    logic [N-1:0] a1, b1, e1, a2, b2, e2;
    logic [K-1:0] d0;
    int l, prev, pulses, span;
    gen_point(a1, b1, e1, c1);
    gen_point(a2, b2, e2, c2);
    d0 = K'($urandom_range(1, 15));
    ex = expect_dec(int'(d0), c1, c2);
    l = exp_lat(d0);
    span = 3 * l + 2;
    x_C1 = a1; y_C1 = b1; z_C1 = e1;
    x_C2 = a2; y_C2 = b2; z_C2 = e2;
    d_key = d0;
    start = 1'b1;
    prev = -1;
    pulses = 0;
    @(posedge clk);
    for (int c = 0; c <= span; c++) begin
      @(negedge clk);
      // Scramble the key whenever it must not be sampled.
      if (busy) d_key = K'($urandom);
      else      d_key = d0;
      if (c == span) start = 1'b0;
      if (Decryption_complete) begin
        pulses++;
        vectors++;
        if (to_affine(x_P, y_P, z_P) !== ex) begin
          miscompares++; $display("FAIL held_start_result: got %0h expected %0h", to_affine(x_P, y_P, z_P), ex);
        end
        if (prev >= 0) begin
          vectors++;
          if (c - prev != l + 1) begin
            miscompares++; $display("FAIL held_start_spacing: got %0d expected %0d", c - prev, l + 1);
          end
        end
        prev = c;
      end
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++; $display("FAIL held_start_pulses: got %0d expected 3", pulses);
    end
    d_key = d0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, pulses; bit bok; pt_t got, c1, c2, ex;
    logic [N-1:0] a1, b1, e1, a2, b2, e2;
    logic [K-1:0] d;
    gen_point(a1, b1, e1, c1);
    gen_point(a2, b2, e2, c2);
    d = K'($urandom);
    d_key = d;
    x_C1 = a1; y_C1 = b1; z_C1 = e1;
    x_C2 = a2; y_C2 = b2; z_C2 = e2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || Decryption_complete !== 1'b0 || {x_P, y_P, z_P} !== '0) begin
      miscompares++; $display("FAIL reset_mid_op: got busy=%0b done=%0b out=%0h expected 0 0 0", busy, Decryption_complete, {x_P, y_P, z_P});
    end
    pulses = 0;
    for (int c = 0; c < 2 * K + 5; c++) begin
      @(negedge clk);
      if (Decryption_complete || busy) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL reset_discard: got %0d activity cycles expected 0", pulses);
    end
    gen_point(a1, b1, e1, c1);
    d = K'($urandom);
    ex = expect_dec(int'(d), c1, c2);
    run_op(d, a1, b1, e1, a2, b2, e2, lat, bok, got);
    vectors++;
    if (got !== ex || lat != exp_lat(d)) begin
      miscompares++; $display("FAIL after_reset_op: got %0h lat=%0d expected %0h lat=%0d", got, lat, ex, exp_lat(d));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 7; x++)
      for (int y = 0; y < 7; y++)
        if (md(y * y) == md(x * x * x + CA * x + CB)) curve_pts.push_back(mk(0, x, y));
    G = mk(0, 2, 3);
    test_reset();
    test_latency();
    test_round_trip();
    test_d_zero();
    test_c1_identity();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
